// File: rtl/golay_pkg.sv
`default_nettype none
// ============================================================================
// Module   : golay_pkg
// Brief    : Shared Golay(23,12) constants and the dispatcher state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package golay_pkg;

    localparam int GOLAY_N = 23;   // codeword length
    localparam int GOLAY_K = 12;   // message length
    localparam int GOLAY_R = 11;   // parity length

    typedef enum logic [1:0] {
        DISP_IDLE  = 2'd0,
        DISP_ISSUE = 2'd1,
        DISP_WAIT  = 2'd2
    } disp_state_e;

endpackage
`default_nettype wire

// File: rtl/golay_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : golay_rx_fifo
// Brief    : Small synchronous FIFO buffering assembled codewords. A push into
//            a full FIFO is accepted when a pop happens on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
module golay_rx_fifo
    import golay_pkg::*;
#(
    parameter int WIDTH = GOLAY_N,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign rdata_o   = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage write; head is read combinationally before the edge overwrites it.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (w_do_push && !w_do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/golay_rx_assembler.sv
`default_nettype none
// ============================================================================
// Module   : golay_rx_assembler
// Brief    : Deserialises received Golay codewords (MSB first), buffers them
//            and dispatches them one at a time to a Golay decoder, holding the
//            codeword steady until the decoder reports completion or times out.
// Revision : 1.0 - initial release
// ============================================================================
module golay_rx_assembler
    import golay_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 8191
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    output logic [GOLAY_N-1:0]            cw_out,
    output logic                          decode_en,
    input  logic                          dec_valid,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          timeout_err,
    output logic [15:0]                   word_cnt
);

    localparam int                CNT_W     = $clog2(GOLAY_N);
    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(GOLAY_N - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    // The 23rd bit is taken straight from bit_in, so only 22 prior bits are stored.
    logic [GOLAY_N-2:0] shreg_q;
    logic [CNT_W-1:0]   bitcnt_q;
    logic [GOLAY_N-1:0] w_word;
    logic               w_word_done;

    logic [GOLAY_N-1:0] w_fifo_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_pop;

    disp_state_e        state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [GOLAY_N-1:0] cw_q, cw_d;
    logic [15:0]        word_cnt_q, word_cnt_d;
    logic               timeout_q, timeout_d;
    logic               overflow_q;

    assign w_word      = {shreg_q, bit_in};
    assign w_word_done = bit_valid && (bitcnt_q == LAST_BIT);

    // Serial-to-parallel shift and bit position tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else if (bit_valid) begin
            shreg_q  <= w_word[GOLAY_N-2:0];
            bitcnt_q <= (bitcnt_q == LAST_BIT) ? '0 : bitcnt_q + CNT_W'(1);
        end
    end

    golay_rx_fifo #(
        .WIDTH (GOLAY_N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_word_done),
        .pop_i   (w_pop),
        .wdata_i (w_word),
        .rdata_o (w_fifo_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (fifo_count)
    );

    // Sticky flag for a completed word that found no room in the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (w_word_done && w_fifo_full && !w_pop) begin
            overflow_q <= 1'b1;
        end
    end

    // Dispatcher next-state: pop in IDLE, pulse in ISSUE, hold in WAIT.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        cw_d       = cw_q;
        word_cnt_d = word_cnt_q;
        timeout_d  = timeout_q;
        w_pop      = 1'b0;
        case (state_q)
            DISP_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop   = 1'b1;
                    cw_d    = w_fifo_head;
                    state_d = DISP_ISSUE;
                end
            end
            DISP_ISSUE: begin
                word_cnt_d = word_cnt_q + 16'd1;
                wait_d     = '0;
                state_d    = DISP_WAIT;
            end
            DISP_WAIT: begin
                if (dec_valid) begin
                    state_d = DISP_IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DISP_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = DISP_IDLE;
            end
        endcase
    end

    // Dispatcher registers; cw_q only changes on a pop so it is stable while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DISP_IDLE;
            wait_q     <= '0;
            cw_q       <= '0;
            word_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            cw_q       <= cw_d;
            word_cnt_q <= word_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign cw_out      = cw_q;
    assign decode_en   = (state_q == DISP_ISSUE);
    assign busy        = (state_q != DISP_IDLE);
    assign word_cnt    = word_cnt_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;

endmodule
`default_nettype wire
